// File: rtl/or8way_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master side drives req; the slave side (the arbiter) returns the grant.
interface or8way_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  modport master (output req, input grant, grant_id, busy, timeout);
  modport slave  (input req, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/or8way_rr_arbiter.sv
// Round-robin arbiter for one shared resource and 8 requesters, registered one-hot grant.
// Define ARB_TIMEOUT_EN to add a HOLD_MAX-cycle hold limit with a revoke pulse and requester masking.
//
//   state | meaning
//   IDLE  | no owner; arbitrates eligible requests starting at ptr
//   GRANT | one requester owns the resource until it drops req (or its hold limit expires)
module or8way_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input logic               clk,
  input logic               reset,
  or8way_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] gid_q, gid_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] mask_q;
  logic [7:0] eligible;
  logic       any_req;
  logic [2:0] pick;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mask_d;
  logic             timeout_q, timeout_d;
`else
  assign mask_q = 8'h00;
`endif

  function automatic logic or8way(input logic [7:0] v);
    return ((v[0] | v[1]) | (v[2] | v[3])) | ((v[4] | v[5]) | (v[6] | v[7]));
  endfunction

  assign eligible = bus.req & ~mask_q;
  assign any_req  = or8way(eligible);

  // First eligible index scanning upward from ptr with wrap; only used when any_req is set.
  always_comb begin
    logic [2:0] idx;
    logic       found;
    pick  = 3'd0;
    idx   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && eligible[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      gid_q   <= 3'd0;
      ptr_q   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      mask_q    <= 8'h00;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    mask_d    = mask_q & bus.req;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = 8'b1 << pick;
          gid_d   = pick;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[gid_q]) begin
          state_d = IDLE;
          grant_d = 8'h00;
          gid_d   = 3'd0;
          ptr_d   = gid_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == HOLD_LAST) begin
          // Forced revoke: owner stays masked until it lets go of req.
          state_d       = IDLE;
          grant_d       = 8'h00;
          gid_d         = 3'd0;
          ptr_d         = gid_q + 3'd1;
          timeout_d     = 1'b1;
          mask_d[gid_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant    = grant_q;
    bus.grant_id = gid_q;
    bus.busy     = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
    bus.timeout  = timeout_q;
`else
    bus.timeout  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_or8way_rr_arbiter.sv
// Directed bench for or8way_rr_arbiter: reset, latency, rotation, wrap, no-preemption
// and mid-grant reset; the hold-limit sequence runs only when ARB_TIMEOUT_EN is defined.
module tb_or8way_rr_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   fails;

  or8way_rr_arbiter_if arb_if ();

`ifdef ARB_TIMEOUT_EN
  or8way_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (arb_if.slave)
  );
`else
  or8way_rr_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (arb_if.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                            input logic to);
    chk({tag, ".grant"},    arb_if.grant,                g);
    chk({tag, ".grant_id"}, {5'b0, arb_if.grant_id},     {5'b0, id});
    chk({tag, ".busy"},     {7'b0, arb_if.busy},         {7'b0, (g != 8'h00)});
    chk({tag, ".timeout"},  {7'b0, arb_if.timeout},      {7'b0, to});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;

    // reset with all requests pending
    reset      = 1'b1;
    arb_if.req = 8'hFF;
    step();
    expect_out("rst_c1", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("rst_c2", 8'h00, 3'd0, 1'b0);

    // basic grant, release, rotation
    reset      = 1'b0;
    arb_if.req = 8'h05;
    step();
    expect_out("first_grant", 8'h01, 3'd0, 1'b0);
    arb_if.req = 8'h04;
    step();
    expect_out("release0", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("grant2", 8'h04, 3'd2, 1'b0);

    // serve 6, then 7 wins over 0, then wrap to 0
    arb_if.req = 8'h40;
    step();
    expect_out("release2", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("grant6", 8'h40, 3'd6, 1'b0);
    arb_if.req = 8'h81;
    step();
    expect_out("release6", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("grant7", 8'h80, 3'd7, 1'b0);
    arb_if.req = 8'h01;
    step();
    expect_out("release7", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("wrap0", 8'h01, 3'd0, 1'b0);

    // owner 3 is not preempted; drop with simultaneous req[5]
    arb_if.req = 8'h08;
    step();
    expect_out("release0b", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("grant3", 8'h08, 3'd3, 1'b0);
    arb_if.req = 8'h0B;
    step();
    expect_out("hold3", 8'h08, 3'd3, 1'b0);
    arb_if.req = 8'h20;
    step();
    expect_out("handoff_gap", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("grant5", 8'h20, 3'd5, 1'b0);

    // reset mid-grant, pointer returns to 0
    arb_if.req = 8'h10;
    step();
    expect_out("release5", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("grant4", 8'h10, 3'd4, 1'b0);
    reset = 1'b1;
    step();
    expect_out("midgrant_rst", 8'h00, 3'd0, 1'b0);
    reset      = 1'b0;
    arb_if.req = 8'h11;
    step();
    expect_out("post_rst_ptr0", 8'h01, 3'd0, 1'b0);

    // no requests: resource stays free
    arb_if.req = 8'h00;
    step();
    expect_out("release_idle", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("stay_idle", 8'h00, 3'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // ptr is 1 here; owner 3 holds past the 4-cycle limit
    arb_if.req = 8'h28;
    step();
    expect_out("to_grant_c1", 8'h08, 3'd3, 1'b0);
    step();
    expect_out("to_grant_c2", 8'h08, 3'd3, 1'b0);
    step();
    expect_out("to_grant_c3", 8'h08, 3'd3, 1'b0);
    step();
    expect_out("to_grant_c4", 8'h08, 3'd3, 1'b0);
    step();
    expect_out("to_revoke", 8'h00, 3'd0, 1'b1);
    step();
    expect_out("to_next5", 8'h20, 3'd5, 1'b0);
    arb_if.req = 8'h08;
    step();
    expect_out("to_release5", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("to_masked_a", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("to_masked_b", 8'h00, 3'd0, 1'b0);
    arb_if.req = 8'h00;
    step();
    expect_out("to_unmask", 8'h00, 3'd0, 1'b0);
    arb_if.req = 8'h08;
    step();
    expect_out("to_regrant3", 8'h08, 3'd3, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
